// File: rtl/mem_wr_seq_pkg.sv
// Shared definitions for the memory-write sequencer: state encoding and
// the default wait-for-acknowledge limit.
package mem_wr_seq_pkg;

    typedef enum logic [1:0] {
        MEM_WR_SEQ_IDLE  = 2'd0,
        MEM_WR_SEQ_BYTE0 = 2'd1,
        MEM_WR_SEQ_BYTE1 = 2'd2
    } mem_wr_seq_state_t;

    localparam int MEM_WR_SEQ_MAX_WAIT = 16;

endpackage

// File: rtl/mem_wr_seq.sv
// Memory-write sequencer: captures a 16-bit internal-bus value and drives one
// or two byte-wide write cycles with a request/acknowledge (WAIT) handshake.
// Wide writes step the address by +1 (lo byte first) or -1 (hi byte first,
// stack push order). A byte that waits too long for mem_ack aborts the write.
module mem_wr_seq
    import mem_wr_seq_pkg::*;
#(
    parameter int MAX_WAIT       = MEM_WR_SEQ_MAX_WAIT,
    parameter int WAIT_CNT_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_start,
    input  logic        wr_wide,
    input  logic        wr_hi_first,
    input  logic [15:0] wr_addr,
    input  logic [15:0] int_bus,
    input  logic        mem_ack,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        overrun
);

    // Timeout is disabled entirely when MAX_WAIT is zero.
    localparam bit TIMEOUT_EN = (MAX_WAIT != 0);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST =
        WAIT_CNT_WIDTH'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

    mem_wr_seq_state_t          state, state_nxt;
    logic [WAIT_CNT_WIDTH-1:0]  wait_cnt, wait_cnt_nxt;
    logic [15:0]                data_q, data_nxt;
    logic                       wide_q, wide_nxt;
    logic                       hi_first_q, hi_first_nxt;
    logic                       mem_wr_nxt;
    logic [15:0]                mem_addr_nxt;
    logic [7:0]                 mem_dout_nxt;
    logic                       done_nxt;
    logic                       err_nxt;
    logic                       overrun_nxt;
    logic                       wait_expired;
    logic                       byte_state;

    assign byte_state   = (state == MEM_WR_SEQ_BYTE0) || (state == MEM_WR_SEQ_BYTE1);
    assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
    assign busy         = byte_state;

    // State, captured request and registered bus outputs; reset aborts any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MEM_WR_SEQ_IDLE;
            wait_cnt    <= '0;
            data_q      <= '0;
            wide_q      <= 1'b0;
            hi_first_q  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_dout    <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            data_q      <= data_nxt;
            wide_q      <= wide_nxt;
            hi_first_q  <= hi_first_nxt;
            mem_wr      <= mem_wr_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_dout    <= mem_dout_nxt;
            done        <= done_nxt;
            err_timeout <= err_nxt;
            overrun     <= overrun_nxt;
        end
    end

    // Next-state and next-output decode; address/data hold their value in IDLE.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        data_nxt     = data_q;
        wide_nxt     = wide_q;
        hi_first_nxt = hi_first_q;
        mem_wr_nxt   = mem_wr;
        mem_addr_nxt = mem_addr;
        mem_dout_nxt = mem_dout;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        overrun_nxt  = 1'b0;

        case (state)
            MEM_WR_SEQ_IDLE: begin
                mem_wr_nxt = 1'b0;
                if (wr_start) begin
                    data_nxt     = int_bus;
                    wide_nxt     = wr_wide;
                    hi_first_nxt = wr_hi_first;
                    state_nxt    = MEM_WR_SEQ_BYTE0;
                    wait_cnt_nxt = '0;
                    mem_wr_nxt   = 1'b1;
                    mem_addr_nxt = wr_addr;
                    mem_dout_nxt = (wr_wide && wr_hi_first) ? int_bus[15:8] : int_bus[7:0];
                end
            end

            MEM_WR_SEQ_BYTE0, MEM_WR_SEQ_BYTE1: begin
                // A new request cannot be queued while a write is in flight.
                overrun_nxt = wr_start;
                if (mem_ack) begin
                    if ((state == MEM_WR_SEQ_BYTE0) && wide_q) begin
                        state_nxt    = MEM_WR_SEQ_BYTE1;
                        wait_cnt_nxt = '0;
                        mem_addr_nxt = hi_first_q ? (mem_addr - 16'd1) : (mem_addr + 16'd1);
                        mem_dout_nxt = hi_first_q ? data_q[7:0] : data_q[15:8];
                    end else begin
                        state_nxt  = MEM_WR_SEQ_IDLE;
                        mem_wr_nxt = 1'b0;
                        done_nxt   = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_nxt  = MEM_WR_SEQ_IDLE;
                    mem_wr_nxt = 1'b0;
                    err_nxt    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt  = MEM_WR_SEQ_IDLE;
                mem_wr_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_wr_seq.sv
// Directed bench for mem_wr_seq with hand-computed expected output vectors.
// Observed vector = {mem_wr, mem_addr, mem_dout, busy, done, err_timeout, overrun}.
module tb_mem_wr_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_start;
    logic        wr_wide;
    logic        wr_hi_first;
    logic [15:0] wr_addr;
    logic [15:0] int_bus;
    logic        mem_ack;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [28:0] obs;
    assign obs = {mem_wr, mem_addr, mem_dout, busy, done, err_timeout, overrun};

    mem_wr_seq #(
        .MAX_WAIT       (4),
        .WAIT_CNT_WIDTH (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_start    (wr_start),
        .wr_wide     (wr_wide),
        .wr_hi_first (wr_hi_first),
        .wr_addr     (wr_addr),
        .int_bus     (int_bus),
        .mem_ack     (mem_ack),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] ev(input logic wr, input logic [15:0] a, input logic [7:0] d,
                                       input logic b, input logic dn, input logic er, input logic ov);
        return {wr, a, d, b, dn, er, ov};
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [28:0] e;
        rst_n = 1'b0; wr_start = 1'b0; wr_wide = 1'b0; wr_hi_first = 1'b0;
        wr_addr = 16'h0; int_bus = 16'h0; mem_ack = 1'b0;
        #1;
        e = ev(0, 16'h0000, 8'h00, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, e); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, e); end
    endtask

    task automatic test_byte8();
        logic [28:0] e;
        wr_start = 1; wr_wide = 0; wr_hi_first = 0; wr_addr = 16'h1234; int_bus = 16'h00A5; mem_ack = 1;
        tick();
        wr_start = 0; int_bus = 16'hFFFF;
        e = ev(1, 16'h1234, 8'hA5, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL b8_byte: got %h want %h", obs, e); end
        tick();
        e = ev(0, 16'h1234, 8'hA5, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL b8_done: got %h want %h", obs, e); end
        tick();
        e = ev(0, 16'h1234, 8'hA5, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL b8_idle: got %h want %h", obs, e); end
    endtask

    task automatic test_lo_first_wrap();
        logic [28:0] e;
        wr_start = 1; wr_wide = 1; wr_hi_first = 0; wr_addr = 16'hFFFF; int_bus = 16'hBEEF; mem_ack = 1;
        tick();
        wr_start = 0; int_bus = 16'h0000;
        e = ev(1, 16'hFFFF, 8'hEF, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL lo_byte0: got %h want %h", obs, e); end
        tick();
        e = ev(1, 16'h0000, 8'hBE, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL lo_byte1: got %h want %h", obs, e); end
        tick();
        e = ev(0, 16'h0000, 8'hBE, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL lo_done: got %h want %h", obs, e); end
    endtask

    task automatic test_hi_first_wait();
        logic [28:0] e;
        logic [15:0] a [2];
        logic [7:0]  d [2];
        a[0] = 16'h0000; a[1] = 16'hFFFF;
        d[0] = 8'h13;    d[1] = 8'h57;
        wr_start = 1; wr_wide = 1; wr_hi_first = 1; wr_addr = 16'h0000; int_bus = 16'h1357; mem_ack = 0;
        tick();
        wr_start = 0; int_bus = 16'hAAAA; wr_addr = 16'h5555;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 3; c++) begin
                e = ev(1, a[b], d[b], 1, 0, 0, 0);
                n_cmp++;
                if (obs !== e) begin
                    n_bad++; $display("FAIL hi_wait b%0d c%0d: got %h want %h", b, c, obs, e);
                end
                mem_ack = (c == 2);
                tick();
            end
        end
        mem_ack = 0;
        e = ev(0, 16'hFFFF, 8'h57, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL hi_done: got %h want %h", obs, e); end
    endtask

    task automatic test_timeout();
        logic [28:0] e;
        wr_start = 1; wr_wide = 0; wr_hi_first = 0; wr_addr = 16'h0042; int_bus = 16'h0011; mem_ack = 0;
        tick();
        wr_start = 0;
        for (int c = 0; c < 4; c++) begin
            e = ev(1, 16'h0042, 8'h11, 1, 0, 0, 0);
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL to_wait c%0d: got %h want %h", c, obs, e); end
            tick();
        end
        e = ev(0, 16'h0042, 8'h11, 0, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL to_abort: got %h want %h", obs, e); end
        tick();
        e = ev(0, 16'h0042, 8'h11, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL to_after: got %h want %h", obs, e); end

        // Acknowledge arriving on the final allowed cycle completes normally.
        wr_start = 1; wr_addr = 16'h0043; int_bus = 16'h0022;
        tick();
        wr_start = 0;
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            tick();
        end
        mem_ack = 0;
        e = ev(0, 16'h0043, 8'h22, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL to_late_ack: got %h want %h", obs, e); end
    endtask

    task automatic test_back_to_back();
        logic [28:0] e;
        wr_start = 1; wr_wide = 1; wr_hi_first = 0; wr_addr = 16'h0100; int_bus = 16'h2211; mem_ack = 1;
        tick();
        wr_start = 0;
        tick();
        e = ev(1, 16'h0101, 8'h22, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL b2b_byte1: got %h want %h", obs, e); end
        wr_start = 1; wr_wide = 0; wr_addr = 16'h0200; int_bus = 16'h0033;
        tick();
        e = ev(0, 16'h0101, 8'h22, 0, 1, 0, 1);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL b2b_overrun: got %h want %h", obs, e); end
        wr_addr = 16'h0300; int_bus = 16'h0044;
        tick();
        wr_start = 0;
        e = ev(1, 16'h0300, 8'h44, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL b2b_accept: got %h want %h", obs, e); end
        tick();
        e = ev(0, 16'h0300, 8'h44, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL b2b_done: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_mid();
        logic [28:0] e;
        wr_start = 1; wr_wide = 1; wr_hi_first = 0; wr_addr = 16'h0500; int_bus = 16'h6655; mem_ack = 0;
        tick();
        wr_start = 0;
        e = ev(1, 16'h0500, 8'h55, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rm_byte0: got %h want %h", obs, e); end
        #2;
        rst_n = 1'b0;
        #1;
        e = ev(0, 16'h0000, 8'h00, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rm_async: got %h want %h", obs, e); end
        mem_ack = 1;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rm_no_done: got %h want %h", obs, e); end
        wr_start = 1; wr_wide = 0; wr_addr = 16'h0600; int_bus = 16'h0077;
        tick();
        wr_start = 0;
        e = ev(1, 16'h0600, 8'h77, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rm_fresh: got %h want %h", obs, e); end
        tick();
        e = ev(0, 16'h0600, 8'h77, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rm_fresh_done: got %h want %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_byte8();
        test_lo_first_wrap();
        test_hi_first_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_wr_seq.md
Name: mem_wr_seq

Overview:
Memory-write sequencer on the outgoing side of the internal bus. It captures a 16-bit internal-bus value and a target address, then drives one or two byte-wide memory write cycles. Each cycle uses a request/acknowledge (WAIT) handshake. It is the write-direction counterpart of the memory-data-in registers that feed the internal bus mux, and it covers LD (nn),rr, PUSH/CALL/RST stack writes and 8-bit stores.

Parameters:
MAX_WAIT, 16, max cycles a byte write may wait for mem_ack before abort; 0 disables timeout
WAIT_CNT_WIDTH, 5, width of wait counter; must hold MAX_WAIT

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_start  input  1  one-cycle request; sampled only in IDLE
wr_wide  input  1  1 = 16-bit write (two bytes), 0 = 8-bit write (int_bus[7:0] only)
wr_hi_first  input  1  16-bit order: 0 = lo@addr then hi@addr+1; 1 = hi@addr then lo@addr-1 (stack push)
wr_addr  input  16  address of first byte
int_bus  input  16  internal bus data, captured on accepted wr_start
mem_ack  input  1  memory accepts current byte this cycle (WAIT released)
mem_wr  output  1  write request, registered
mem_addr  output  16  byte address, registered
mem_dout  output  8  byte data, registered
busy  output  1  high in BYTE0/BYTE1
done  output  1  one-cycle pulse after last byte acknowledged
err_timeout  output  1  one-cycle pulse on timeout abort
overrun  output  1  one-cycle pulse when wr_start arrives while busy (request dropped)

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; data/address/mode registers 0; wait counter 0. Reset mid-write aborts immediately. mem_wr drops with rst_n. No done or err pulse follows.
- States: IDLE, BYTE0, BYTE1.
- IDLE, wr_start=1 at edge N:
  - Latch int_bus, wr_wide and wr_hi_first.
  - Go to BYTE0. From cycle N+1: mem_wr=1, mem_addr=wr_addr, mem_dout = hi_first&&wide ? int_bus[15:8] : int_bus[7:0].
- BYTE0/BYTE1: outputs held stable until mem_ack=1 at a rising edge. Ack in the same cycle mem_wr first rises counts, giving a zero-wait byte of 1 cycle.
- BYTE0 + ack:
  - If wide: go to BYTE1. Next cycle mem_addr = first addr +1 (lo-first) or -1 (hi-first), modulo 2^16, so FFFF+1=0000 and 0000-1=FFFF. mem_dout = the other byte. mem_wr stays 1 with no gap.
  - If not wide: go to IDLE, mem_wr=0, done=1 for one cycle.
- BYTE1 + ack: go to IDLE, mem_wr=0, done=1 for one cycle.
- Minimum latency from wr_start to done: 8-bit = 2 cycles; 16-bit = 3 cycles.
- done cycle is IDLE, so a wr_start in that cycle is accepted (back-to-back, no bubble).
- mem_addr/mem_dout keep their last value in IDLE. Only mem_wr is qualified.
- wr_start while busy: ignored, overrun=1 next cycle, transfer in progress unaffected.
- Wait counter:
  - Cleared on entry to each byte state.
  - Increments each cycle without ack.
  - If MAX_WAIT≠0 and counter reaches MAX_WAIT-1 with ack still 0: next edge goes to IDLE, mem_wr=0, err_timeout=1 for one cycle, no done.
  - Ack on that same final cycle wins (normal progress).
- Captured data is immune to int_bus changes after acceptance.

Decomposition:
- Shared package/header, alongside the existing bus-width definitions: state encoding constants (MEM_WR_SEQ_IDLE/BYTE0/BYTE1, 2 bits) and the MAX_WAIT default.
- No sub-module: address step is a single 16-bit ±1 adder and the wait counter is inline.

Test Plan:
- 8-bit write, wr_addr=1234, int_bus=00A5, mem_ack tied 1 -> one cycle mem_wr=1, addr 1234, dout A5; done next cycle; busy high 1 cycle.
- 16-bit lo-first, addr=FFFF, int_bus=BEEF, ack tied 1 -> byte FFFF=EF then 0000=BE on consecutive cycles; done 3 cycles after wr_start.
- 16-bit hi-first (push), addr=0000, int_bus=1357, ack delayed 2 cycles per byte -> FFFF... wait: addr 0000=13 held 3 cycles, then FFFF=57 held 3 cycles; outputs stable throughout wait; then done.
- MAX_WAIT=4, ack never asserted -> mem_wr high exactly 4 cycles, then err_timeout pulse, no done, state IDLE; same run with ack on the 4th cycle -> normal completion.
- wr_start during BYTE1, plus a new wr_start in the done cycle -> overrun pulse, first transfer unchanged; done-cycle request accepted with mem_wr rising next cycle.
- rst_n low during BYTE0 of a 16-bit write -> mem_wr=0 asynchronously, no done; after release a fresh 8-bit write completes normally.
